// File: rtl/pong_pkg.sv
// Shared state encoding, widths and ball-box type for the pong rule controller.
package pong_pkg;
  localparam int COORD_W = 12;
  localparam int SCORE_W = 4;
  localparam int CW1     = COORD_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } ball_box_t;

  // One spare bit so pad + size never wraps in the range compares.
  function automatic logic [COORD_W:0] ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/pong_rules_if.sv
// Animator/paddle-facing signal bundle of the pong rule controller.
interface pong_rules_if;
  import pong_pkg::*;

  logic               i_ani_stb;
  logic               i_start;
  logic [COORD_W-1:0] i_ball_x1;
  logic [COORD_W-1:0] i_ball_x2;
  logic [COORD_W-1:0] i_ball_y1;
  logic [COORD_W-1:0] i_ball_y2;
  logic [COORD_W-1:0] i_pad_l_y;
  logic [COORD_W-1:0] i_pad_r_y;
  logic               o_animate;
  logic               o_ball_rst;
  logic               o_hit_l;
  logic               o_hit_r;
  logic [SCORE_W-1:0] o_score_l;
  logic [SCORE_W-1:0] o_score_r;
  logic [2:0]         o_state;
  logic               o_game_over;
  logic [7:0]         o_rally;

  modport slave (
    input  i_ani_stb, i_start, i_ball_x1, i_ball_x2, i_ball_y1, i_ball_y2,
           i_pad_l_y, i_pad_r_y,
    output o_animate, o_ball_rst, o_hit_l, o_hit_r, o_score_l, o_score_r,
           o_state, o_game_over, o_rally
  );

  modport master (
    output i_ani_stb, i_start, i_ball_x1, i_ball_x2, i_ball_y1, i_ball_y2,
           i_pad_l_y, i_pad_r_y,
    input  o_animate, o_ball_rst, o_hit_l, o_hit_r, o_score_l, o_score_r,
           o_state, o_game_over, o_rally
  );
endinterface

// File: rtl/pong_box_hit.sv
// Combinational ball-box vs paddle overlap test, one instance per paddle.
module pong_box_hit import pong_pkg::*; #(
  parameter int PAD_W = 10,
  parameter int PAD_H = 80
) (
  input  ball_box_t          i_box,
  input  logic [COORD_W-1:0] i_pad_x,
  input  logic [COORD_W-1:0] i_pad_y,
  output logic               o_hit
);
  localparam logic [COORD_W:0] W_EXT = CW1'(PAD_W);
  localparam logic [COORD_W:0] H_M1  = CW1'(PAD_H - 1);

  logic x_ovl;
  logic y_ovl;

  always_comb begin
    x_ovl = (ext(i_box.x1) <= ext(i_pad_x) + W_EXT) && (ext(i_box.x2) >= ext(i_pad_x));
    y_ovl = (ext(i_box.y2) >= ext(i_pad_y)) && (ext(i_box.y1) <= ext(i_pad_y) + H_M1);
    o_hit = x_ovl && y_ovl;
  end
endmodule

// File: rtl/pong_rules.sv
// Pong game-rule controller: hit/miss detection, scoring and serve/play sequencing.
// Optional rally counter is built only when PONG_RALLY_EN is defined.
module pong_rules import pong_pkg::*; #(
  parameter int D_WIDTH      = 640,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 80,
  parameter int PAD_XL       = 20,
  parameter int PAD_XR       = 610,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pong_rules_if.slave  bus
);
  localparam logic [COORD_W-1:0] PXL    = COORD_W'(PAD_XL);
  localparam logic [COORD_W-1:0] PXR    = COORD_W'(PAD_XR);
  localparam logic [COORD_W:0]   XL_LO  = CW1'(PAD_XL);
  localparam logic [COORD_W:0]   XL_HI  = CW1'(PAD_XL + PAD_W);
  localparam logic [COORD_W:0]   XR_LO  = CW1'(PAD_XR);
  localparam logic [COORD_W:0]   XR_HI  = CW1'(PAD_XR + PAD_W);
  localparam logic [COORD_W:0]   MISS_R = CW1'(D_WIDTH - 2);
  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);

  ball_box_t box;
  logic      hit_l_raw, hit_r_raw;
  logic      in_xl, in_xr, miss_l, miss_r;

  assign box = {bus.i_ball_x1, bus.i_ball_x2, bus.i_ball_y1, bus.i_ball_y2};

  pong_box_hit #(.PAD_W(PAD_W), .PAD_H(PAD_H)) u_hit_l (
    .i_box(box), .i_pad_x(PXL), .i_pad_y(bus.i_pad_l_y), .o_hit(hit_l_raw)
  );
  pong_box_hit #(.PAD_W(PAD_W), .PAD_H(PAD_H)) u_hit_r (
    .i_box(box), .i_pad_x(PXR), .i_pad_y(bus.i_pad_r_y), .o_hit(hit_r_raw)
  );

  always_comb begin
    in_xl  = (ext(box.x1) <= XL_HI) && (ext(box.x2) >= XL_LO);
    in_xr  = (ext(box.x1) <= XR_HI) && (ext(box.x2) >= XR_LO);
    miss_l = ext(box.x1) <= CW1'(1);
    miss_r = ext(box.x2) >= MISS_R;
  end

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               armed_l_q, armed_l_d, armed_r_q, armed_r_d;
  logic               scorer_l_q, scorer_l_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               ball_rst_q, ball_rst_d;
  logic               animate_q, animate_d;
  logic               hit_l_q, hit_l_d, hit_r_q, hit_r_d;
  logic               game_over_q, game_over_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_l_d  = armed_l_q;
    armed_r_d  = armed_r_q;
    scorer_l_d = scorer_l_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hit_l_d    = 1'b0;
    hit_r_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.i_start) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // The first SERVE cycle only loads the counter; a strobe there is dropped.
        if (bus.i_ani_stb && !ball_rst_q) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (bus.i_ani_stb) begin
          if (!in_xl) armed_l_d = 1'b1;
          if (!in_xr) armed_r_d = 1'b1;
          // A disarmed geometric hit still owns its priority slot, so it also blocks misses.
          if (hit_l_raw) begin
            if (armed_l_q) begin
              hit_l_d   = 1'b1;
              armed_l_d = 1'b0;
            end
          end else if (hit_r_raw) begin
            if (armed_r_q) begin
              hit_r_d   = 1'b1;
              armed_r_d = 1'b0;
            end
          end else if (miss_l) begin
            scorer_l_d = 1'b0;
            state_d    = ST_POINT;
          end else if (miss_r) begin
            scorer_l_d = 1'b1;
            state_d    = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (scorer_l_q) begin
          score_l_d = score_l_q + SCORE_W'(1);
          state_d   = (score_l_d == WIN) ? ST_OVER : ST_SERVE;
        end else begin
          score_r_d = score_r_q + SCORE_W'(1);
          state_d   = (score_r_d == WIN) ? ST_OVER : ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ball_rst_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (ball_rst_d) begin
      cnt_d     = 8'(SERVE_FRAMES);
      armed_l_d = 1'b1;
      armed_r_d = 1'b1;
    end
    animate_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      armed_l_q   <= 1'b1;
      armed_r_q   <= 1'b1;
      scorer_l_q  <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      ball_rst_q  <= 1'b0;
      animate_q   <= 1'b0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_l_q   <= armed_l_d;
      armed_r_q   <= armed_r_d;
      scorer_l_q  <= scorer_l_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      ball_rst_q  <= ball_rst_d;
      animate_q   <= animate_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      game_over_q <= game_over_d;
    end
  end

`ifdef PONG_RALLY_EN
  logic [7:0] rally_q, rally_d;

  // Counts alongside the hit pulse so o_rally and o_hit_* update together.
  always_comb begin
    rally_d = rally_q;
    if (ball_rst_d) rally_d = '0;
    else if ((hit_l_d || hit_r_d) && (rally_q != 8'hFF)) rally_d = rally_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rally_q <= '0;
    else       rally_q <= rally_d;
  end

  assign bus.o_rally = rally_q;
`else
  assign bus.o_rally = '0;
`endif

  assign bus.o_state     = state_q;
  assign bus.o_animate   = animate_q;
  assign bus.o_ball_rst  = ball_rst_q;
  assign bus.o_hit_l     = hit_l_q;
  assign bus.o_hit_r     = hit_r_q;
  assign bus.o_score_l   = score_l_q;
  assign bus.o_score_r   = score_r_q;
  assign bus.o_game_over = game_over_q;
endmodule
